// File: rtl/fp_divsqrt_pool_pkg.sv
// Shared types for the FP div/sqrt unit pool: slot states, unit index, flag width
// and the active-list range check used by selective flush.
package fp_divsqrt_pool_pkg;

    localparam int FFLAGS_PATH  = 5;
    localparam int ALPTR_MAX_W  = 16;
    localparam int UNIT_INDEX_W = 4;

    typedef enum logic [1:0] {
        DS_FREE     = 2'd0,
        DS_RESERVED = 2'd1,
        DS_BUSY     = 2'd2,
        DS_DONE     = 2'd3
    } divsqrt_unit_state_e;

    typedef logic [UNIT_INDEX_W-1:0] divsqrt_unit_index_t;
    typedef logic [FFLAGS_PATH-1:0]  fflags_path_t;

    // Pointer lies in the ring range [head, tail); head == tail is an empty range.
    function automatic logic selective_flush_detector(
        input logic                   valid,
        input logic                   full,
        input logic [ALPTR_MAX_W-1:0] head,
        input logic [ALPTR_MAX_W-1:0] tail,
        input logic [ALPTR_MAX_W-1:0] ptr
    );
        logic hit;
        if (head <= tail) begin
            hit = (ptr >= head) && (ptr < tail);
        end else begin
            hit = (ptr >= head) || (ptr < tail);
        end
        return valid && (full || hit);
    endfunction

endpackage

// File: rtl/fp_divsqrt_pool_if.sv
// Lane-side handshake between the FP issue/exec stages and the div/sqrt pool.
interface fp_divsqrt_pool_if #(
    parameter int FP_LANES    = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ALPTR_WIDTH = 6
);
    import fp_divsqrt_pool_pkg::*;

    logic [FP_LANES-1:0]             reserve_req;
    logic [FP_LANES-1:0]             reserve_grant;
    logic [FP_LANES-1:0]             start_req;
    logic [FP_LANES*ALPTR_WIDTH-1:0] start_alptr;
    logic [FP_LANES-1:0]             start_is_div;
    logic [FP_LANES*DATA_WIDTH-1:0]  start_a;
    logic [FP_LANES*DATA_WIDTH-1:0]  start_b;
    logic [FP_LANES*3-1:0]           start_rm;
    logic [FP_LANES-1:0]             finished;
    logic [FP_LANES*DATA_WIDTH-1:0]  data_out;
    logic [FP_LANES*FFLAGS_PATH-1:0] fflags_out;
    logic [FP_LANES-1:0]             release_req;

    modport master (
        output reserve_req, start_req, start_alptr, start_is_div,
               start_a, start_b, start_rm, release_req,
        input  reserve_grant, finished, data_out, fflags_out
    );

    modport slave (
        input  reserve_req, start_req, start_alptr, start_is_div,
               start_a, start_b, start_rm, release_req,
        output reserve_grant, finished, data_out, fflags_out
    );

endinterface

// File: rtl/fp_divsqrt_unit_slot.sv
// One pool slot: FREE/RESERVED/BUSY/DONE FSM, owning lane, alptr tag,
// registered operands towards the core and the latched result.
module fp_divsqrt_unit_slot
    import fp_divsqrt_pool_pkg::*;
#(
    parameter int FP_LANES    = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ALPTR_WIDTH = 6,
    parameter int LANE_W      = (FP_LANES > 1) ? $clog2(FP_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic                            grant,
    input  logic [LANE_W-1:0]               grant_lane,
    input  logic [FP_LANES-1:0]             start_req,
    input  logic [FP_LANES*ALPTR_WIDTH-1:0] start_alptr,
    input  logic [FP_LANES-1:0]             start_is_div,
    input  logic [FP_LANES*DATA_WIDTH-1:0]  start_a,
    input  logic [FP_LANES*DATA_WIDTH-1:0]  start_b,
    input  logic [FP_LANES*3-1:0]           start_rm,
    input  logic [FP_LANES-1:0]             release_req,
    input  logic                            flush_valid,
    input  logic                            flush_all,
    input  logic [ALPTR_WIDTH-1:0]          flush_head,
    input  logic [ALPTR_WIDTH-1:0]          flush_tail,
    input  logic                            unit_done,
    input  logic [DATA_WIDTH-1:0]           unit_result,
    input  logic [FFLAGS_PATH-1:0]          unit_fflags,
    output divsqrt_unit_state_e             state,
    output logic [LANE_W-1:0]               owner,
    output logic [DATA_WIDTH-1:0]           result,
    output logic [FFLAGS_PATH-1:0]          fflags,
    output logic                            unit_start,
    output logic                            unit_abort,
    output logic                            unit_is_div,
    output logic [DATA_WIDTH-1:0]           unit_a,
    output logic [DATA_WIDTH-1:0]           unit_b,
    output logic [2:0]                      unit_rm
);

    divsqrt_unit_state_e      state_r, state_n_s;
    logic [LANE_W-1:0]        owner_r, owner_n_s;
    logic [ALPTR_WIDTH-1:0]   tag_r;
    logic                     start_r, is_div_r;
    logic [DATA_WIDTH-1:0]    a_r, b_r, result_r;
    logic [2:0]               rm_r;
    logic [FFLAGS_PATH-1:0]   fflags_r;
    logic                     load_op_s, load_res_s, abort_s;
    logic                     tag_hit_s, start_hit_s;
    logic                     sel_start_s, sel_release_s;
    logic [ALPTR_WIDTH-1:0]   sel_alptr_s;

    assign sel_start_s   = start_req[owner_r];
    assign sel_release_s = release_req[owner_r];
    assign sel_alptr_s   = start_alptr[int'(owner_r)*ALPTR_WIDTH +: ALPTR_WIDTH];

    assign tag_hit_s = selective_flush_detector(flush_valid, flush_all,
        ALPTR_MAX_W'(flush_head), ALPTR_MAX_W'(flush_tail), ALPTR_MAX_W'(tag_r));
    // An op whose tag is being flushed as it starts must not reach the core.
    assign start_hit_s = selective_flush_detector(flush_valid, flush_all,
        ALPTR_MAX_W'(flush_head), ALPTR_MAX_W'(flush_tail), ALPTR_MAX_W'(sel_alptr_s));

    // Next-state: flush beats unit_done, which beats start/release.
    always_comb begin
        state_n_s  = state_r;
        owner_n_s  = owner_r;
        load_op_s  = 1'b0;
        load_res_s = 1'b0;
        abort_s    = 1'b0;
        if (rst) begin
            state_n_s = DS_FREE;
            abort_s   = (state_r == DS_BUSY);
        end else begin
            case (state_r)
                DS_FREE: begin
                    if (grant) begin
                        state_n_s = DS_RESERVED;
                        owner_n_s = grant_lane;
                    end else begin
                        state_n_s = DS_FREE;
                    end
                end
                DS_RESERVED: begin
                    if (flush_valid && flush_all) begin
                        state_n_s = DS_FREE;
                    end else if (sel_start_s && !stall) begin
                        if (start_hit_s) begin
                            state_n_s = DS_FREE;
                        end else begin
                            state_n_s = DS_BUSY;
                            load_op_s = 1'b1;
                        end
                    end else begin
                        state_n_s = DS_RESERVED;
                    end
                end
                DS_BUSY: begin
                    if (tag_hit_s) begin
                        state_n_s = DS_FREE;
                        abort_s   = !unit_done;
                    end else if (unit_done) begin
                        state_n_s  = DS_DONE;
                        load_res_s = 1'b1;
                    end else begin
                        state_n_s = DS_BUSY;
                    end
                end
                DS_DONE: begin
                    if (tag_hit_s || (sel_release_s && !stall)) begin
                        state_n_s = DS_FREE;
                    end else begin
                        state_n_s = DS_DONE;
                    end
                end
                default: state_n_s = DS_FREE;
            endcase
        end
    end

    // State, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= DS_FREE;
            owner_r  <= '0;
            tag_r    <= '0;
            start_r  <= 1'b0;
            is_div_r <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            rm_r     <= 3'd0;
            result_r <= '0;
            fflags_r <= '0;
        end else begin
            state_r <= state_n_s;
            owner_r <= owner_n_s;
            start_r <= load_op_s;
            if (load_op_s) begin
                tag_r    <= sel_alptr_s;
                is_div_r <= start_is_div[owner_r];
                a_r      <= start_a[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
                b_r      <= start_b[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];
                rm_r     <= start_rm[int'(owner_r)*3 +: 3];
            end
            if (load_res_s) begin
                result_r <= unit_result;
                fflags_r <= unit_fflags;
            end
        end
    end

    assign state       = state_r;
    assign owner       = owner_r;
    assign result      = result_r;
    assign fflags      = fflags_r;
    assign unit_start  = start_r;
    assign unit_abort  = abort_s;
    assign unit_is_div = is_div_r;
    assign unit_a      = a_r;
    assign unit_b      = b_r;
    assign unit_rm     = rm_r;

endmodule

// File: rtl/fp_divsqrt_pool.sv
// Pool of DIVSQRT_UNITS iterative div/sqrt slots shared by FP_LANES lanes:
// grant arbiter, per-unit slots and the lane-side result muxes.
module fp_divsqrt_pool
    import fp_divsqrt_pool_pkg::*;
#(
    parameter int FP_LANES      = 2,
    parameter int DIVSQRT_UNITS = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int ALPTR_WIDTH   = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                stall,
    fp_divsqrt_pool_if.slave                    lane,
    input  logic                                flush_valid,
    input  logic                                flush_all,
    input  logic [ALPTR_WIDTH-1:0]              flush_head,
    input  logic [ALPTR_WIDTH-1:0]              flush_tail,
    output logic [DIVSQRT_UNITS-1:0]            unit_start,
    output logic [DIVSQRT_UNITS-1:0]            unit_abort,
    output logic [DIVSQRT_UNITS-1:0]            unit_is_div,
    output logic [DIVSQRT_UNITS*DATA_WIDTH-1:0] unit_a,
    output logic [DIVSQRT_UNITS*DATA_WIDTH-1:0] unit_b,
    output logic [DIVSQRT_UNITS*3-1:0]          unit_rm,
    input  logic [DIVSQRT_UNITS-1:0]            unit_done,
    input  logic [DIVSQRT_UNITS*DATA_WIDTH-1:0] unit_result,
    input  logic [DIVSQRT_UNITS*FFLAGS_PATH-1:0] unit_fflags
);

    localparam int LANE_W = (FP_LANES > 1) ? $clog2(FP_LANES) : 1;

    divsqrt_unit_state_e          slot_state_s  [DIVSQRT_UNITS];
    logic [LANE_W-1:0]            slot_owner_s  [DIVSQRT_UNITS];
    logic [DATA_WIDTH-1:0]        slot_result_s [DIVSQRT_UNITS];
    logic [FFLAGS_PATH-1:0]       slot_fflags_s [DIVSQRT_UNITS];
    logic [LANE_W-1:0]            slot_lane_s   [DIVSQRT_UNITS];
    logic [DIVSQRT_UNITS-1:0]     slot_grant_s;
    logic [DIVSQRT_UNITS-1:0]     avail_s;
    logic [FP_LANES-1:0]          owns_s, fin_s, grant_s;
    logic [FP_LANES*DATA_WIDTH-1:0]  data_s;
    logic [FP_LANES*FFLAGS_PATH-1:0] flags_s;
    logic                         block_s;

    assign block_s = rst || stall || flush_valid;

    // Ownership map and lane-side mux of finished/result/flags.
    always_comb begin
        owns_s  = '0;
        fin_s   = '0;
        data_s  = '0;
        flags_s = '0;
        for (int l = 0; l < FP_LANES; l++) begin
            for (int u = 0; u < DIVSQRT_UNITS; u++) begin
                if (slot_state_s[u] != DS_FREE && slot_owner_s[u] == LANE_W'(l)) begin
                    owns_s[l] = 1'b1;
                    if (slot_state_s[u] == DS_DONE) begin
                        fin_s[l] = 1'b1;
                        data_s[l*DATA_WIDTH +: DATA_WIDTH]    = slot_result_s[u];
                        flags_s[l*FFLAGS_PATH +: FFLAGS_PATH] = slot_fflags_s[u];
                    end else begin
                        fin_s[l] = fin_s[l];
                    end
                end else begin
                    owns_s[l] = owns_s[l];
                end
            end
        end
    end

    // Ascending-lane arbiter; each lane takes the lowest FREE unit left over.
    always_comb begin
        grant_s      = '0;
        slot_grant_s = '0;
        for (int u = 0; u < DIVSQRT_UNITS; u++) begin
            slot_lane_s[u] = '0;
            avail_s[u]     = (slot_state_s[u] == DS_FREE);
        end
        for (int l = 0; l < FP_LANES; l++) begin
            for (int u = 0; u < DIVSQRT_UNITS; u++) begin
                if (!block_s && lane.reserve_req[l] && !owns_s[l] && !grant_s[l] && avail_s[u]) begin
                    grant_s[l]      = 1'b1;
                    slot_grant_s[u] = 1'b1;
                    slot_lane_s[u]  = LANE_W'(l);
                    avail_s[u]      = 1'b0;
                end else begin
                    avail_s[u] = avail_s[u];
                end
            end
        end
    end

    assign lane.reserve_grant = grant_s;
    assign lane.finished      = fin_s;
    assign lane.data_out      = data_s;
    assign lane.fflags_out    = flags_s;

    for (genvar u = 0; u < DIVSQRT_UNITS; u++) begin : g_slot
        fp_divsqrt_unit_slot #(
            .FP_LANES    (FP_LANES),
            .DATA_WIDTH  (DATA_WIDTH),
            .ALPTR_WIDTH (ALPTR_WIDTH),
            .LANE_W      (LANE_W)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .stall        (stall),
            .grant        (slot_grant_s[u]),
            .grant_lane   (slot_lane_s[u]),
            .start_req    (lane.start_req),
            .start_alptr  (lane.start_alptr),
            .start_is_div (lane.start_is_div),
            .start_a      (lane.start_a),
            .start_b      (lane.start_b),
            .start_rm     (lane.start_rm),
            .release_req  (lane.release_req),
            .flush_valid  (flush_valid),
            .flush_all    (flush_all),
            .flush_head   (flush_head),
            .flush_tail   (flush_tail),
            .unit_done    (unit_done[u]),
            .unit_result  (unit_result[u*DATA_WIDTH +: DATA_WIDTH]),
            .unit_fflags  (unit_fflags[u*FFLAGS_PATH +: FFLAGS_PATH]),
            .state        (slot_state_s[u]),
            .owner        (slot_owner_s[u]),
            .result       (slot_result_s[u]),
            .fflags       (slot_fflags_s[u]),
            .unit_start   (unit_start[u]),
            .unit_abort   (unit_abort[u]),
            .unit_is_div  (unit_is_div[u]),
            .unit_a       (unit_a[u*DATA_WIDTH +: DATA_WIDTH]),
            .unit_b       (unit_b[u*DATA_WIDTH +: DATA_WIDTH]),
            .unit_rm      (unit_rm[u*3 +: 3])
        );
    end

endmodule
